data_mem_port: RTL and testbench
================================

Name: data_mem_port

Overview:
- Load/store unit between the CPU execute stage and the data port (port A) of the word-addressed RAM.
- Converts byte-addressed, sized CPU requests into a word address, a byte-enable mask and lane-replicated write data.
- The RAM registers its address and returns q one cycle later; this block captures that word and aligns, zero-extends or sign-extends it.
- Flags misaligned, out-of-range and bad-size requests; flagged requests never touch the RAM.

Parameters:
- RAM_WORDS_LOG2, 15, log2 of implemented RAM words; byte addresses at or above 2^(RAM_WORDS_LOG2+2) are out of range.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request rejected (misaligned, out of range or illegal size).
- ram_wren  out  1  RAM write enable.
- ram_address  out  30  RAM word address, req_addr[31:2].
- ram_data  out  32  RAM write data.
- ram_byteena  out  4  RAM byte enables.
- ram_q  in  32  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Reset values: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, captured offset/size/unsigned=0. While rst=1: ram_wren=0 and req_ready=0.
- States:
  - IDLE: req_ready=1.
  - LOAD: req_ready=0.
- Accept: a request is accepted on a cycle with req_valid and req_ready both 1.
- Error check at accept; err=1 when any of:
  - size 11;
  - size 01 with addr[0]=1;
  - size 10 with addr[1:0]!=0;
  - addr[31:RAM_WORDS_LOG2+2] nonzero.
- RAM outputs are combinational from the request in the accept cycle, so the RAM samples the address on the accept edge:
  - ram_address = req_addr[31:2];
  - ram_wren = accept & req_we & ~err;
  - when no accept, ram_wren=0 and ram_address may hold any value.
- Byte enables:
  - byte: 4'b0001 << addr[1:0];
  - half: addr[1] ? 1100 : 0011;
  - word: 1111;
  - forced to 0000 on err.
- Write data lane replication:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- Store or error accepted in cycle N:
  - resp_valid=1 in N+1;
  - resp_err=err, resp_rdata=0;
  - state stays IDLE, so back-to-back stores run at 1 per cycle.
- Load accepted in cycle N without error:
  - register addr[1:0], size and unsigned; go to LOAD in N+1.
  - In N+1, select ram_q lane:
    - byte: ram_q[8*off+:8];
    - half: off[1] ? ram_q[31:16] : ram_q[15:0].
  - Extend per req_unsigned.
  - Register into resp_rdata with resp_valid=1 in N+2 and return to IDLE.
  - Next accept is possible in N+2, so load throughput is 1 per 2 cycles.
- No response backpressure: resp_valid is a single-cycle pulse and is 0 on every other cycle. resp_rdata/resp_err hold their last value while resp_valid=0.
- Reset during LOAD: return to IDLE immediately, no response issued. A store whose edge has already passed is committed in RAM.
- Reset in the accept cycle: the request is dropped and no write occurs.

Decomposition:
- Package data_mem_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_BAD localparams;
  - state encoding IDLE/LOAD;
  - byteena lookup function.
- Sub-module load_align: combinational lane select plus zero/sign extension (inputs q, offset, size, unsigned; output 32-bit result), reusable by an instruction-fetch or debug read port.

Test Plan:
1. Store word 0xDEADBEEF at 0x100, then load word 0x100: RAM word 0x40 written with byteena 1111; load resp_valid 2 cycles after accept with rdata 0xDEADBEEF, err 0.
2. Store byte 0x80 at 0x103, then signed byte load at 0x103: byteena 1000, ram_data 0x80808080; load rdata 0xFFFFFF80. Unsigned load of the same address gives 0x00000080; word load at 0x100 gives 0x80ADBEEF.
3. Signed halfword load at 0x102 after a word store of 0x8001_1234: rdata 0xFFFF8001. Halfword load at 0x101: err=1, rdata 0, resp_valid 1 cycle after accept, no RAM access.
4. Word store at 0x0002_0000 (RAM_WORDS_LOG2=15) and size=11 store at 0x0: both err=1, ram_wren never asserted, RAM contents unchanged.
5. Four back-to-back stores with req_valid held high: req_ready stays 1 and one resp_valid per cycle. A following load deasserts req_ready for exactly 1 cycle.
6. rst pulsed in the cycle after a load accept: resp_valid stays 0, req_ready returns to 1 after release, and the next load completes normally.

Source files
------------

// File: rtl/data_mem_pkg.sv
//------------------------------------------------------------------------------
// Module   : data_mem_pkg
// Brief    : Shared size codes, port FSM encoding and byte-enable lookup.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package data_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic logic [3:0] byteena_f(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
//------------------------------------------------------------------------------
// Module   : load_align
// Brief    : Selects the addressed lane of a RAM word and zero/sign-extends it.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] q,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (offset)
      2'd0:    w_byte = q[7:0];
      2'd1:    w_byte = q[15:8];
      2'd2:    w_byte = q[23:16];
      default: w_byte = q[31:24];
    endcase
    w_half = offset[1] ? q[31:16] : q[15:0];
    case (size)
      SIZE_BYTE: result = {{24{~is_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: result = {{16{~is_unsigned & w_half[15]}}, w_half};
      default:   result = q;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_port.sv
//------------------------------------------------------------------------------
// Module   : data_mem_port
// Brief    : Load/store unit driving the word-addressed data RAM port A.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_port
  import data_mem_pkg::*;
#(
  parameter int RAM_WORDS_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_wren,
  output logic [29:0] ram_address,
  output logic [31:0] ram_data,
  output logic [3:0]  ram_byteena,
  input  logic [31:0] ram_q
);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        w_accept;
  logic        w_err;
  logic        w_load_go;
  logic [31:0] w_aligned;

  assign req_ready = (r_state == IDLE) & ~rst;
  assign w_accept  = req_valid & req_ready;

  assign w_err = (|req_addr[31:RAM_WORDS_LOG2+2])
               | (req_size == SIZE_BAD)
               | ((req_size == SIZE_HALF) & req_addr[0])
               | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00));

  assign w_load_go = w_accept & ~req_we & ~w_err;

  // RAM samples these on the accept edge; rejected requests never reach it.
  assign ram_address = req_addr[31:2];
  assign ram_wren    = w_accept & req_we & ~w_err;
  assign ram_byteena = w_err ? 4'b0000 : byteena_f(req_size, req_addr[1:0]);

  always_comb begin
    case (req_size)
      SIZE_BYTE: ram_data = {4{req_wdata[7:0]}};
      SIZE_HALF: ram_data = {2{req_wdata[15:0]}};
      default:   ram_data = req_wdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_load_go) w_state_next = LOAD;
      LOAD:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  load_align u_load_align (
    .q           (ram_q),
    .offset      (r_off),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .result      (w_aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      r_off      <= 2'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (r_state == LOAD) begin
        resp_valid <= 1'b1;
        resp_rdata <= w_aligned;
        resp_err   <= 1'b0;
      end else if (w_accept) begin
        if (req_we | w_err) begin
          resp_valid <= 1'b1;
          resp_err   <= w_err;
          resp_rdata <= 32'd0;
        end else begin
          r_off      <= req_addr[1:0];
          r_size     <= req_size;
          r_unsigned <= req_unsigned;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_port.sv
//------------------------------------------------------------------------------
// Module   : tb_data_mem_port
// Brief    : Directed self-checking bench for data_mem_port with a RAM model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_port;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_wren;
  logic [29:0] ram_address;
  logic [31:0] ram_data;
  logic [3:0]  ram_byteena;
  logic [31:0] ram_q;

  logic [31:0] mem [0:1023];
  int          wr_count;
  int          n_pass;
  int          n_tot;

  logic        obs_ready, obs_wren;
  logic [3:0]  obs_be;
  logic [31:0] obs_data;
  logic [29:0] obs_addr;

  always #5 clk = ~clk;

  data_mem_port #(.RAM_WORDS_LOG2(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_wren     (ram_wren),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_byteena  (ram_byteena),
    .ram_q        (ram_q)
  );

  // RAM model: byte-enabled write, registered address, old data on read.
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteena[b]) mem[ram_address[9:0]][8*b +: 8] <= ram_data[8*b +: 8];
      wr_count <= wr_count + 1;
    end
    ram_q <= mem[ram_address[9:0]];
  end

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    obs_ready = req_ready; obs_wren = ram_wren; obs_be = ram_byteena;
    obs_data = ram_data; obs_addr = ram_address;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         output logic v1, output logic rdy1, output logic v2,
                         output logic [31:0] rd, output logic er);
    send(1'b0, size, uns, addr, 32'h0);
    v1 = resp_valid; rdy1 = req_ready;
    @(negedge clk);
    v2 = resp_valid; rd = resp_rdata; er = resp_err;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    n_tot++; if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", req_ready); else n_pass++;
    n_tot++; if (ram_wren !== 1'b0) $display("FAIL rst_wren: got %b want 0", ram_wren); else n_pass++;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_tot++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_tot++; if (resp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", resp_rdata); else n_pass++;
    n_tot++; if (resp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", resp_err); else n_pass++;
    n_tot++; if (req_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", req_ready); else n_pass++;
    n_tot++; if (mem[10'h0C0] !== 32'h0) $display("FAIL rst_dropped_store: got %h want 0", mem[10'h0C0]); else n_pass++;
  endtask

  task automatic test_word;
    logic v1, rdy1, v2, er;
    logic [31:0] rd;
    send(1'b1, SZ_W, 1'b0, 32'h100, 32'hDEADBEEF);
    n_tot++; if (obs_wren !== 1'b1) $display("FAIL sw_wren: got %b want 1", obs_wren); else n_pass++;
    n_tot++; if (obs_addr !== 30'h40) $display("FAIL sw_addr: got %h want 40", obs_addr); else n_pass++;
    n_tot++; if (obs_be !== 4'b1111) $display("FAIL sw_be: got %b want 1111", obs_be); else n_pass++;
    n_tot++; if (obs_data !== 32'hDEADBEEF) $display("FAIL sw_data: got %h want deadbeef", obs_data); else n_pass++;
    n_tot++; if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h0})
      $display("FAIL sw_resp: got v=%b e=%b d=%h want v=1 e=0 d=0", resp_valid, resp_err, resp_rdata); else n_pass++;
    do_load(SZ_W, 1'b0, 32'h100, v1, rdy1, v2, rd, er);
    n_tot++; if (obs_wren !== 1'b0) $display("FAIL lw_wren: got %b want 0", obs_wren); else n_pass++;
    n_tot++; if ({v1, rdy1} !== 2'b00) $display("FAIL lw_n1: got v=%b rdy=%b want 0 0", v1, rdy1); else n_pass++;
    n_tot++; if ({v2, er} !== 2'b10) $display("FAIL lw_n2: got v=%b e=%b want 1 0", v2, er); else n_pass++;
    n_tot++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", rd); else n_pass++;
    @(negedge clk);
    n_tot++; if (resp_valid !== 1'b0) $display("FAIL lw_pulse: got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_byte;
    logic v1, rdy1, v2, er;
    logic [31:0] rd;
    send(1'b1, SZ_B, 1'b0, 32'h103, 32'h12345680);
    n_tot++; if (obs_be !== 4'b1000) $display("FAIL sb_be: got %b want 1000", obs_be); else n_pass++;
    n_tot++; if (obs_data !== 32'h80808080) $display("FAIL sb_data: got %h want 80808080", obs_data); else n_pass++;
    do_load(SZ_B, 1'b0, 32'h103, v1, rdy1, v2, rd, er);
    n_tot++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_signed: got %h want ffffff80", rd); else n_pass++;
    do_load(SZ_B, 1'b1, 32'h103, v1, rdy1, v2, rd, er);
    n_tot++; if (rd !== 32'h00000080) $display("FAIL lbu: got %h want 00000080", rd); else n_pass++;
    do_load(SZ_B, 1'b0, 32'h101, v1, rdy1, v2, rd, er);
    n_tot++; if (rd !== 32'hFFFFFFBE) $display("FAIL lb_off1: got %h want ffffffbe", rd); else n_pass++;
    do_load(SZ_W, 1'b0, 32'h100, v1, rdy1, v2, rd, er);
    n_tot++; if (rd !== 32'h80ADBEEF) $display("FAIL lb_word: got %h want 80adbeef", rd); else n_pass++;
  endtask

  task automatic test_half;
    logic v1, rdy1, v2, er;
    logic [31:0] rd;
    send(1'b1, SZ_W, 1'b0, 32'h100, 32'h80011234);
    do_load(SZ_H, 1'b0, 32'h102, v1, rdy1, v2, rd, er);
    n_tot++; if (rd !== 32'hFFFF8001) $display("FAIL lh_signed: got %h want ffff8001", rd); else n_pass++;
    do_load(SZ_H, 1'b1, 32'h100, v1, rdy1, v2, rd, er);
    n_tot++; if (rd !== 32'h00001234) $display("FAIL lhu_low: got %h want 00001234", rd); else n_pass++;
    send(1'b1, SZ_H, 1'b0, 32'h102, 32'h5555ABCD);
    n_tot++; if (obs_be !== 4'b1100) $display("FAIL sh_be: got %b want 1100", obs_be); else n_pass++;
    n_tot++; if (obs_data !== 32'hABCDABCD) $display("FAIL sh_data: got %h want abcdabcd", obs_data); else n_pass++;
    do_load(SZ_W, 1'b0, 32'h100, v1, rdy1, v2, rd, er);
    n_tot++; if (rd !== 32'hABCD1234) $display("FAIL sh_word: got %h want abcd1234", rd); else n_pass++;
  endtask

  task automatic test_errors;
    int wc;
    logic v1, rdy1, v2, er;
    logic [31:0] rd;
    send(1'b1, SZ_W, 1'b0, 32'h0, 32'h55AA55AA);
    @(negedge clk);
    wc = wr_count;
    send(1'b1, SZ_W, 1'b0, 32'h0002_0000, 32'hFFFFFFFF);
    n_tot++; if ({obs_wren, obs_be} !== 5'b0) $display("FAIL oor_ram: got wren=%b be=%b want 0 0000", obs_wren, obs_be); else n_pass++;
    n_tot++; if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h0})
      $display("FAIL oor_resp: got v=%b e=%b d=%h want v=1 e=1 d=0", resp_valid, resp_err, resp_rdata); else n_pass++;
    send(1'b1, SZ_X, 1'b0, 32'h0, 32'h12345678);
    n_tot++; if (obs_wren !== 1'b0) $display("FAIL badsz_wren: got %b want 0", obs_wren); else n_pass++;
    n_tot++; if ({resp_valid, resp_err} !== 2'b11) $display("FAIL badsz_resp: got v=%b e=%b want 1 1", resp_valid, resp_err); else n_pass++;
    send(1'b1, SZ_W, 1'b0, 32'h2, 32'h77777777);
    n_tot++; if ({obs_wren, resp_err} !== 2'b01) $display("FAIL sw_misalign: got wren=%b e=%b want 0 1", obs_wren, resp_err); else n_pass++;
    send(1'b0, SZ_H, 1'b0, 32'h101, 32'h0);
    n_tot++; if (obs_be !== 4'b0000) $display("FAIL lh_mis_be: got %b want 0000", obs_be); else n_pass++;
    n_tot++; if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h0})
      $display("FAIL lh_mis_resp: got v=%b e=%b d=%h want v=1 e=1 d=0", resp_valid, resp_err, resp_rdata); else n_pass++;
    n_tot++; if (req_ready !== 1'b1) $display("FAIL lh_mis_ready: got %b want 1", req_ready); else n_pass++;
    @(negedge clk);
    n_tot++; if ({resp_valid, resp_err} !== 2'b01) $display("FAIL err_hold: got v=%b e=%b want 0 1", resp_valid, resp_err); else n_pass++;
    n_tot++; if (wr_count !== wc) $display("FAIL err_no_write: got %0d want %0d", wr_count, wc); else n_pass++;
    do_load(SZ_W, 1'b0, 32'h0, v1, rdy1, v2, rd, er);
    n_tot++; if ({v2, er, rd} !== {2'b10, 32'h55AA55AA}) $display("FAIL err_ram_intact: got %h e=%b want 55aa55aa e=0", rd, er); else n_pass++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
      req_addr = 32'h200 + 32'(4 * i); req_wdata = 32'h11110000 + 32'(i);
      #1;
      n_tot++; if (req_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready); else n_pass++;
      if (i > 0) begin
        n_tot++; if (resp_valid !== 1'b1) $display("FAIL b2b_resp%0d: got %b want 1", i, resp_valid); else n_pass++;
      end
      @(negedge clk);
    end
    n_tot++; if (resp_valid !== 1'b1) $display("FAIL b2b_resp3: got %b want 1", resp_valid); else n_pass++;
    req_we = 1'b0; req_addr = 32'h208;
    #1;
    n_tot++; if (req_ready !== 1'b1) $display("FAIL b2b_ld_ready0: got %b want 1", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    n_tot++; if ({req_ready, resp_valid} !== 2'b00) $display("FAIL b2b_ld_n1: got rdy=%b v=%b want 0 0", req_ready, resp_valid); else n_pass++;
    @(negedge clk);
    n_tot++; if ({req_ready, resp_valid} !== 2'b11) $display("FAIL b2b_ld_n2: got rdy=%b v=%b want 1 1", req_ready, resp_valid); else n_pass++;
    n_tot++; if (resp_rdata !== 32'h11110002) $display("FAIL b2b_ld_data: got %h want 11110002", resp_rdata); else n_pass++;
  endtask

  task automatic test_reset_load;
    logic v1, rdy1, v2, er;
    logic [31:0] rd;
    send(1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
    rst = 1'b1;
    #1;
    n_tot++; if ({resp_valid, req_ready} !== 2'b00) $display("FAIL rl_during: got v=%b rdy=%b want 0 0", resp_valid, req_ready); else n_pass++;
    @(negedge clk);
    n_tot++; if (resp_valid !== 1'b0) $display("FAIL rl_no_resp: got %b want 0", resp_valid); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_tot++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL rl_after: got v=%b rdy=%b want 0 1", resp_valid, req_ready); else n_pass++;
    do_load(SZ_W, 1'b0, 32'h100, v1, rdy1, v2, rd, er);
    n_tot++; if ({v1, v2, er, rd} !== {3'b010, 32'hABCD1234}) $display("FAIL rl_next_load: got v1=%b v2=%b e=%b d=%h want 0 1 0 abcd1234", v1, v2, er, rd); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_tot = 0;
    wr_count = 0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_back_to_back;
    test_reset_load;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
